// File: rtl/configurable_division_pkg.sv
// ---------------------------------------------------------------------------
// configurable_division_pkg
//
// Shared definitions for the configurable signed divider:
//   - cm_i mode encodings (MODE_S8, MODE_D8, MODE_S16)
//   - FSM state enum (IDLE, CALC, FIX, DONE)
//   - operand widths and restoring-iteration counts
//   - small helpers for magnitude / conditional negation and mode folding
//
// Optional feature macro used by the importing top: DIV_BY_ZERO_DETECT_EN
// ---------------------------------------------------------------------------
package configurable_division_pkg;

   // Operand widths.
   localparam int unsigned W_WIDE   = 16;
   localparam int unsigned W_NARROW = 8;

   // Iteration counter and iteration counts per mode.
   localparam int unsigned CNT_W       = 5;
   localparam logic [CNT_W-1:0] ITER_WIDE   = 5'd16;
   localparam logic [CNT_W-1:0] ITER_NARROW = 5'd8;

   // cm_i encodings; 2'b11 is folded onto MODE_S16.
   localparam logic [1:0] MODE_S8  = 2'b00;
   localparam logic [1:0] MODE_D8  = 2'b01;
   localparam logic [1:0] MODE_S16 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Map any cm_i value onto one of the three real modes.
   function automatic logic [1:0] fold_mode(input logic [1:0] cm);
      return ((cm == MODE_S8) || (cm == MODE_D8)) ? cm : MODE_S16;
   endfunction

   // Two's-complement magnitude; 0x8000 / 0x80 map to themselves, which is
   // the correct unsigned magnitude.
   function automatic logic [15:0] mag16(input logic [15:0] v);
      return v[15] ? 16'(~v + 16'd1) : v;
   endfunction

   function automatic logic [7:0] mag8(input logic [7:0] v);
      return v[7] ? 8'(~v + 8'd1) : v;
   endfunction

   // Negate when neg is set; wraps naturally on overflow.
   function automatic logic [15:0] cond_neg16(input logic [15:0] v, input logic neg);
      return neg ? 16'(16'd0 - v) : v;
   endfunction

   function automatic logic [7:0] cond_neg8(input logic [7:0] v, input logic neg);
      return neg ? 8'(8'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_restore_lane.sv
// ---------------------------------------------------------------------------
// div_restore_lane
//
// Unsigned restoring-division lane, one iteration per step.  The dividend is
// loaded MSB-first into a shift register; each step shifts one dividend bit
// into the partial remainder, trial-subtracts the divisor and shifts the
// resulting quotient bit in at the bottom.  After k steps the low k bits of
// quotient_o hold the quotient of the top k dividend bits, so a narrower
// operand can be run through a wider lane by left-aligning it.
//
// Ports:
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   load_i       load operands, clear partial remainder
//   step_i       perform one restoring iteration
//   dividend_i   unsigned dividend (WIDTH)
//   divisor_i    unsigned divisor (WIDTH)
//   quotient_o   quotient / remaining dividend bits (WIDTH)
//   remainder_o  partial remainder (WIDTH)
// ---------------------------------------------------------------------------
module div_restore_lane #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // NOTE: combinational blocks assign every output before any condition so
   // no latch can be inferred; here both are assigned unconditionally.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
   end

   // shifted < 2*divisor, so a non-negative trial always fits in WIDTH bits
   // and its top bit is a clean borrow flag.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (load_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/configurable_division.sv
// ---------------------------------------------------------------------------
// configurable_division
//
// Iterative signed divider (truncate toward zero, remainder takes the sign
// of the dividend) with three modes selected by cm_i:
//   00  single 8-bit  (operand bits [7:0], results sign-extended to 16)
//   01  two parallel 8-bit lanes ([7:0] and [15:8])
//   10  single 16-bit (11 behaves as 10)
// FSM: IDLE -> CALC (N restoring iterations) -> FIX (sign correction) ->
// DONE.  data_valid_o rises on the first DONE edge, N+2 edges after capture.
// enable_i is a level request: dropping it aborts CALC/FIX or releases DONE.
//
// Optional feature: define DIV_BY_ZERO_DETECT_EN to flag zero divisors per
// lane, force that lane's quotient to all ones and remainder to the dividend,
// and skip CALC when every active lane has a zero divisor.  Without it
// div_by_zero_o is tied to 0.
//
// Ports:
//   clk_i          clock
//   reset_ni       asynchronous active-low reset
//   enable_i       level request: start / hold result
//   cm_i [1:0]     mode select
//   dividend_i     signed dividend (16)
//   divisor_i      signed divisor (16)
//   quotient_o     quotient (16), 0 while data_valid_o=0
//   remainder_o    remainder (16), 0 while data_valid_o=0
//   data_valid_o   result valid
//   div_by_zero_o  per-lane divide-by-zero flag (2), 0 while invalid
// ---------------------------------------------------------------------------
module configurable_division
   import configurable_division_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        enable_i,
   input  logic [1:0]  cm_i,
   input  logic [15:0] dividend_i,
   input  logic [15:0] divisor_i,
   output logic [15:0] quotient_o,
   output logic [15:0] remainder_o,
   output logic        data_valid_o,
   output logic [1:0]  div_by_zero_o
);

   state_e           state_q;
   logic [CNT_W-1:0] iter_q;
   logic [1:0]       mode_q;

   // Captured sign information: quotient negative / dividend negative per lane.
   logic q_neg0_q, r_neg0_q;
   logic q_neg1_q, r_neg1_q;

   logic [15:0] res_quo_q;
   logic [15:0] res_rem_q;
   logic        valid_q;

   // ---------------- capture-side decode ----------------
   logic [1:0]  cm_fold;
   logic        wide_in;
   logic        start;
   logic [15:0] lane0_dvd_in, lane0_dvs_in;
   logic [7:0]  lane1_dvd_in, lane1_dvs_in;
   logic        dvd_sgn0_in, dvs_sgn0_in;
   logic        skip_calc;

   assign cm_fold = fold_mode(cm_i);
   assign wide_in = (cm_fold == MODE_S16);
   assign start   = (state_q == ST_IDLE) && enable_i;

   always_comb begin
      dvd_sgn0_in = wide_in ? dividend_i[15] : dividend_i[7];
      dvs_sgn0_in = wide_in ? divisor_i[15]  : divisor_i[7];
      // Narrow operands are left-aligned so 8 steps leave the quotient in [7:0].
      lane0_dvd_in = wide_in ? mag16(dividend_i) : {mag8(dividend_i[7:0]), 8'h00};
      lane0_dvs_in = wide_in ? mag16(divisor_i)  : {8'h00, mag8(divisor_i[7:0])};
      lane1_dvd_in = mag8(dividend_i[15:8]);
      lane1_dvs_in = mag8(divisor_i[15:8]);
   end

`ifdef DIV_BY_ZERO_DETECT_EN
   logic [1:0]  dbz_in;
   logic [1:0]  dbz_q;
   logic [1:0]  res_dbz_q;
   logic [15:0] dividend_q;

   always_comb begin
      dbz_in[0] = wide_in ? (divisor_i == 16'h0000) : (divisor_i[7:0] == 8'h00);
      dbz_in[1] = (cm_fold == MODE_D8) && (divisor_i[15:8] == 8'h00);
      // Dual-lane mode only skips when both lanes have nothing to compute.
      skip_calc = (cm_fold == MODE_D8) ? (&dbz_in) : dbz_in[0];
   end
`else
   assign skip_calc = 1'b0;
`endif

   // ---------------- datapath lanes ----------------
   logic        step;
   logic [15:0] lane0_quo, lane0_rem;
   logic [7:0]  lane1_quo, lane1_rem;

   assign step = (state_q == ST_CALC);

   div_restore_lane #(.WIDTH(W_WIDE)) u_lane0 (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .load_i      (start),
      .step_i      (step),
      .dividend_i  (lane0_dvd_in),
      .divisor_i   (lane0_dvs_in),
      .quotient_o  (lane0_quo),
      .remainder_o (lane0_rem)
   );

   div_restore_lane #(.WIDTH(W_NARROW)) u_lane1 (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .load_i      (start),
      .step_i      (step),
      .dividend_i  (lane1_dvd_in),
      .divisor_i   (lane1_dvs_in),
      .quotient_o  (lane1_quo),
      .remainder_o (lane1_rem)
   );

   // ---------------- sign correction (FIX) ----------------
   logic [15:0] wide_q, wide_r;
   logic [7:0]  lo_q, lo_r, hi_q, hi_r;
   logic [15:0] fix_quo, fix_rem;

   always_comb begin
      wide_q = cond_neg16(lane0_quo, q_neg0_q);
      wide_r = cond_neg16(lane0_rem, r_neg0_q);
      lo_q   = cond_neg8(lane0_quo[7:0], q_neg0_q);
      lo_r   = cond_neg8(lane0_rem[7:0], r_neg0_q);
      hi_q   = cond_neg8(lane1_quo, q_neg1_q);
      hi_r   = cond_neg8(lane1_rem, r_neg1_q);
`ifdef DIV_BY_ZERO_DETECT_EN
      if (dbz_q[0]) begin
         wide_q = '1;
         wide_r = dividend_q;
         lo_q   = '1;
         lo_r   = dividend_q[7:0];
      end
      if (dbz_q[1]) begin
         hi_q = '1;
         hi_r = dividend_q[15:8];
      end
`endif
      case (mode_q)
         MODE_S8: begin
            fix_quo = {{8{lo_q[7]}}, lo_q};
            fix_rem = {{8{lo_r[7]}}, lo_r};
         end
         MODE_D8: begin
            fix_quo = {hi_q, lo_q};
            fix_rem = {hi_r, lo_r};
         end
         default: begin
            fix_quo = wide_q;
            fix_rem = wide_r;
         end
      endcase
   end

   // ---------------- control FSM ----------------
   logic last_iter;
   assign last_iter = (iter_q == ((mode_q == MODE_S16) ? (ITER_WIDE - 5'd1)
                                                       : (ITER_NARROW - 5'd1)));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         iter_q    <= '0;
         mode_q    <= MODE_S8;
         q_neg0_q  <= 1'b0;
         r_neg0_q  <= 1'b0;
         q_neg1_q  <= 1'b0;
         r_neg1_q  <= 1'b0;
         res_quo_q <= '0;
         res_rem_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  mode_q   <= cm_fold;
                  q_neg0_q <= dvd_sgn0_in ^ dvs_sgn0_in;
                  r_neg0_q <= dvd_sgn0_in;
                  q_neg1_q <= dividend_i[15] ^ divisor_i[15];
                  r_neg1_q <= dividend_i[15];
                  iter_q   <= '0;
                  state_q  <= skip_calc ? ST_FIX : ST_CALC;
               end
            end
            ST_CALC: begin
               if (!enable_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  iter_q <= iter_q + 5'd1;
                  if (last_iter) state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (!enable_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  res_quo_q <= fix_quo;
                  res_rem_q <= fix_rem;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!enable_i) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end else begin
                  valid_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DIV_BY_ZERO_DETECT_EN
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         dbz_q      <= '0;
         res_dbz_q  <= '0;
         dividend_q <= '0;
      end else begin
         if (start) begin
            dbz_q      <= dbz_in;
            dividend_q <= dividend_i;
         end
         if ((state_q == ST_FIX) && enable_i) res_dbz_q <= dbz_q;
      end
   end

   assign div_by_zero_o = valid_q ? res_dbz_q : 2'b00;
`else
   assign div_by_zero_o = 2'b00;
`endif

   // Results are gated so nothing stale is visible while invalid.
   assign data_valid_o = valid_q;
   assign quotient_o   = valid_q ? res_quo_q : 16'h0000;
   assign remainder_o  = valid_q ? res_rem_q : 16'h0000;

endmodule

// File: tb/tb_configurable_division.sv
// ---------------------------------------------------------------------------
// tb_configurable_division
//
// Directed bench for configurable_division: each step drives one operation,
// counts edges from the capture edge to data_valid_o and compares results
// against hand-computed values.  Honours DIV_BY_ZERO_DETECT_EN.
// ---------------------------------------------------------------------------
module tb_configurable_division;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [1:0]  cm;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        data_valid;
   logic [1:0]  div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   configurable_division dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .enable_i      (enable),
      .cm_i          (cm),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .data_valid_o  (data_valid),
      .div_by_zero_o (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request and return #1 after the capture edge.
   task automatic start_op(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1;
      cm = mode; dividend = a; divisor = b; enable = 1'b1;
      @(posedge clk); #1;
   endtask

   // Watch n edges and report whether data_valid_o was ever seen high.
   task automatic watch(input int n, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (data_valid) seen = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] mode,
                         input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] eq,
                         input logic [15:0] er, input logic [1:0] edbz,
                         input bit check_vals);
      int cyc;
      start_op(mode, a, b);
      // Operands and mode changed after capture must not matter.
      cm = ~mode; dividend = ~a; divisor = b ^ 16'h5A5A;
      check({tag, "_q_zero_while_busy"}, {16'h0, quotient}, 32'h0);
      cyc = 0;
      while (!data_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_dbz"}, {30'h0, div_by_zero}, {30'h0, edbz});
      if (check_vals) begin
         check({tag, "_quotient"}, {16'h0, quotient}, {16'h0, eq});
         check({tag, "_remainder"}, {16'h0, remainder}, {16'h0, er});
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'h0, data_valid}, 32'h1);
      if (check_vals) check({tag, "_hold_q"}, {16'h0, quotient}, {16'h0, eq});
      enable = 1'b0;
      @(posedge clk); #1;
      check({tag, "_release_valid"}, {31'h0, data_valid}, 32'h0);
      check({tag, "_release_out"}, {quotient, remainder}, 32'h0);
   endtask

   initial begin
      bit seen;
      reset_n = 1'b0; enable = 1'b0; cm = 2'b00; dividend = '0; divisor = '0;
      #2;
      check("reset_valid", {31'h0, data_valid}, 32'h0);
      check("reset_out", {quotient, remainder}, 32'h0);
      check("reset_dbz", {30'h0, div_by_zero}, 32'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      watch(5, seen);
      check("idle_no_valid", {31'h0, seen}, 32'h0);

      // Mode 10 / 11
      run_op("m10_pos", 2'b10, 16'h5527, 16'h0007, 18, 16'h0C2A, 16'h0001, 2'b00, 1'b1);
      run_op("m10_neg", 2'b10, 16'hAAD9, 16'h0007, 18, 16'hF3D6, 16'hFFFF, 2'b00, 1'b1);
      run_op("m10_ovf", 2'b10, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 2'b00, 1'b1);
      run_op("m11_as10", 2'b11, 16'h0064, 16'hFFF9, 18, 16'hFFF2, 16'h0002, 2'b00, 1'b1);
      // Mode 01
      run_op("m01_lanes", 2'b01, 16'h64F6, 16'h0703, 10, 16'h0EFD, 16'h02FF, 2'b00, 1'b1);
      run_op("m01_ovf", 2'b01, 16'h8080, 16'hFFFF, 10, 16'h8080, 16'h0000, 2'b00, 1'b1);
      // Mode 00 (upper operand bytes ignored)
      run_op("m00_basic", 2'b00, 16'hAB27, 16'h0005, 10, 16'h0007, 16'h0004, 2'b00, 1'b1);
      run_op("m00_neg", 2'b00, 16'h7EE5, 16'h3304, 10, 16'hFFFA, 16'hFFFD, 2'b00, 1'b1);
      run_op("m00_ovf", 2'b00, 16'hFF80, 16'h12FF, 10, 16'hFF80, 16'h0000, 2'b00, 1'b1);

`ifdef DIV_BY_ZERO_DETECT_EN
      run_op("dbz_m10", 2'b10, 16'h1234, 16'h0000, 2, 16'hFFFF, 16'h1234, 2'b01, 1'b1);
      run_op("dbz_m00", 2'b00, 16'h12F0, 16'hFF00, 2, 16'hFFFF, 16'hFFF0, 2'b01, 1'b1);
      run_op("dbz_m01_hi", 2'b01, 16'h0A64, 16'h0007, 10, 16'hFF0E, 16'h0A02, 2'b10, 1'b1);
      run_op("dbz_m01_both", 2'b01, 16'h8005, 16'h0000, 2, 16'hFFFF, 16'h8005, 2'b11, 1'b1);
`else
      run_op("zero_div_m10", 2'b10, 16'h1234, 16'h0000, 18, 16'h0000, 16'h0000, 2'b00, 1'b0);
`endif

      // Asynchronous reset while a valid result is shown.
      start_op(2'b10, 16'h5527, 16'h0007);
      repeat (18) @(posedge clk);
      #1 check("pre_reset_valid", {31'h0, data_valid}, 32'h1);
      #3 reset_n = 1'b0;
      #1;
      check("async_reset_valid", {31'h0, data_valid}, 32'h0);
      check("async_reset_out", {quotient, remainder}, 32'h0);
      enable = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;

      // Reset at cycle 5 of CALC discards the operation.
      start_op(2'b10, 16'h5527, 16'h0007);
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("calc_reset_valid", {31'h0, data_valid}, 32'h0);
      check("calc_reset_out", {quotient, remainder}, 32'h0);
      check("calc_reset_dbz", {30'h0, div_by_zero}, 32'h0);
      enable = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      watch(25, seen);
      check("calc_reset_stays_idle", {31'h0, seen}, 32'h0);

      // enable dropped during CALC aborts; a fresh operation then works.
      start_op(2'b10, 16'h5527, 16'h0007);
      repeat (4) @(posedge clk);
      #1 enable = 1'b0;
      watch(25, seen);
      check("abort_calc_no_valid", {31'h0, seen}, 32'h0);
      run_op("after_abort", 2'b10, 16'hAAD9, 16'h0007, 18, 16'hF3D6, 16'hFFFF, 2'b00, 1'b1);

      // enable dropped while in FIX (mode 00: edge 8 enters FIX).
      start_op(2'b00, 16'h0027, 16'h0005);
      repeat (8) @(posedge clk);
      #1 enable = 1'b0;
      watch(15, seen);
      check("abort_fix_no_valid", {31'h0, seen}, 32'h0);
      run_op("after_fix_abort", 2'b01, 16'h64F6, 16'h0703, 10, 16'h0EFD, 16'h02FF, 2'b00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
